pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_skid_buf.sv | 35 +++
 rtl/pipe_stage_reg.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for pipe_stage_reg and pipe_skid_buf.
//   state_e     : stage state; encoding equals entries held (occupancy)
//   OCC_W       : width of the occupancy / state field
//   ZERO_BUBBLE : a drain and an accept may happen in the same cycle
package pipe_pkg;
  localparam int OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam bit ZERO_BUBBLE = 1'b1;
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf -- one-entry data+valid holding register used as the skid slot.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear of valid and data (highest priority)
//   load       : capture in_data, set valid
//   unload     : drop valid (data kept, it is dead once valid falls)
//   valid/data : held entry
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= in_data;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- registered valid/ready pipeline stage with stall counter.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready/in_data    : upstream handshake
//   out_valid/out_ready/out_data : downstream handshake, outputs registered
//   flush                 : synchronous kill of all held entries
//   stall_clr             : synchronous clear of stall_cnt
//   occupancy             : entries held (0..2)
//   stall_cnt             : saturating count of out_valid & !out_ready cycles
// Build option: define PIPE_STAGE_SKID_EN for the two-entry skid version with
// registered in_ready; default is a single entry with combinational in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic             stall_clr,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [OCC_W-1:0] state;
  logic             accept;
  logic             drain;

  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  assign occupancy = state;

`ifdef PIPE_STAGE_SKID_EN
  logic             ready_q;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             skid_clr;
  logic             skid_load;
  logic             skid_unload;

  // Registered ready: no path from out_ready to in_ready.
  assign in_ready    = ready_q;
  // Invalid encoding recovery also scrubs the skid slot.
  assign skid_clr    = flush | (&state);
  assign skid_load   = (state == BUSY) & accept & ~drain;
  assign skid_unload = (state == FULL) & drain;

  pipe_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (skid_clr),
    .load    (skid_load),
    .unload  (skid_unload),
    .in_data (in_data),
    .valid   (skid_valid),
    .data    (skid_data)
  );
`else
  // Single entry: accept when empty, or when the held entry leaves this cycle.
  assign in_ready = ~out_valid | (ZERO_BUBBLE & out_ready);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef PIPE_STAGE_SKID_EN
      ready_q   <= 1'b0;
`endif
    end else if (flush) begin
      // Anything accepted this cycle is dropped with the held entries.
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef PIPE_STAGE_SKID_EN
      ready_q   <= 1'b1;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= BUSY;
            out_valid <= 1'b1;
            out_data  <= in_data;
          end
`ifdef PIPE_STAGE_SKID_EN
          ready_q <= 1'b1;
`endif
        end
        BUSY: begin
          if (accept && drain) begin
            out_data <= in_data;
          end else if (drain) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
          end else if (accept) begin
            // Output stalled: new payload goes to the skid slot, head holds.
            state   <= FULL;
            ready_q <= 1'b0;
`endif
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        FULL: begin
          if (drain) begin
            state     <= BUSY;
            out_valid <= skid_valid;
            out_data  <= skid_data;
            ready_q   <= 1'b1;
          end
        end
`endif
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          out_data  <= '0;
`ifdef PIPE_STAGE_SKID_EN
          ready_q   <= 1'b1;
`endif
        end
      endcase
    end
  end

  // Stall counter is independent of flush; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg -- scoreboard bench for pipe_stage_reg.
// The reference model is a queue of held payloads (capacity 1, or 2 in the
// skid build) plus an integer stall count; the monitor pops the queue on
// every output handshake and checks order.
module tb_pipe_stage_reg;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             flush = 1'b0;
  logic             stall_clr = 1'b0;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  int tests = 0;
  int fails = 0;
  logic [WIDTH-1:0] q[$];
  int mcnt = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .stall_clr (stall_clr),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: got no event expected event within budget", nm);
  endtask

  task automatic check_state();
    chk("occupancy", WIDTH'(occupancy), WIDTH'(q.size()));
    chk("out_valid", WIDTH'(out_valid), WIDTH'(q.size() > 0));
    chk("stall_cnt", WIDTH'(stall_cnt), WIDTH'(mcnt));
    if (q.size() > 0) chk("out_data_head", out_data, q[0]);
  endtask

  // Called at posedge+1; drives one cycle and updates the model at the edge.
  task automatic cycle(input bit iv, input logic [WIDTH-1:0] d, input bit ordy,
                       input bit fl, input bit clr, output bit acc);
    bit rdy;
    int occ0;
    check_state();
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    stall_clr = clr;
    #1;
    occ0 = q.size();
    rdy  = (CAP == 2) ? (occ0 < 2) : (occ0 == 0 || ordy);
    chk("in_ready", WIDTH'(in_ready), WIDTH'(rdy));
    acc = iv && rdy;
    @(posedge clk);
    if (clr) mcnt = 0;
    else if (occ0 > 0 && !ordy && mcnt < CMAX) mcnt++;
    if (fl) q.delete();
    else if (acc) q.push_back(d);
    #1;
  endtask

  // Monitor: every output handshake must deliver the model's head entry.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got %0h expected nothing", out_data);
        end else begin
          chk("out_order", out_data, q.pop_front());
        end
      end
    end
  end

  initial begin
    bit a;
    int n;
    #1;
    chk("rst_out_valid", WIDTH'(out_valid), '0);
    chk("rst_occupancy", WIDTH'(occupancy), '0);
    chk("rst_stall_cnt", WIDTH'(stall_cnt), '0);
    chk("rst_out_data", out_data, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", WIDTH'(in_ready), 32'd1);

    // Single transfer with downstream ready.
    cycle(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, a);
    chk("s1_accept", WIDTH'(a), 32'd1);
    chk("s1_out_valid", WIDTH'(out_valid), 32'd1);
    chk("s1_out_data", out_data, 32'hA5A5A5A5);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, a);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, a);
    chk("s1_drained", WIDTH'(occupancy), '0);

    // Stream 1,2,3 with downstream stalled for the first 3 cycles.
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, a);
    n = 0;
    for (int v = 1; v <= 3; v++) begin
      a = 1'b0;
      for (int k = 0; k < 20 && !a; k++) begin
        cycle(1'b1, WIDTH'(v), n >= 3, 1'b0, 1'b0, a);
        n++;
      end
      if (!a) fail_now("s2_accept_timeout");
    end
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, a);

    // Flush while holding, with 0x55 offered in the same cycle.
    cycle(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, a);
    cycle(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, a);
    cycle(1'b1, 32'h55, 1'b0, 1'b1, 1'b0, a);
    chk("flush_out_valid", WIDTH'(out_valid), '0);
    chk("flush_occupancy", WIDTH'(occupancy), '0);
    chk("flush_out_data", out_data, '0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, a);

    // Long stall: counter saturates, then clears.
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
    cycle(1'b1, 32'h77, 1'b0, 1'b0, 1'b0, a);
    repeat (20) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, a);
    chk("stall_saturate", WIDTH'(stall_cnt), WIDTH'(CMAX));
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
    chk("stall_clear", WIDTH'(stall_cnt), '0);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, a);

    // Randomized traffic.
    repeat (400) begin
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, a);
    end

    // Asynchronous reset between edges while holding payload.
    cycle(1'b1, 32'hBEEF, 1'b0, 1'b0, 1'b0, a);
    cycle(1'b1, 32'hCAFE, 1'b0, 1'b0, 1'b0, a);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", WIDTH'(out_valid), '0);
    chk("async_rst_occupancy", WIDTH'(occupancy), '0);
    chk("async_rst_stall_cnt", WIDTH'(stall_cnt), '0);
    chk("async_rst_out_data", out_data, '0);
    q.delete();
    mcnt = 0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_rerst", WIDTH'(in_ready), 32'd1);
    cycle(1'b1, 32'h1234, 1'b1, 1'b0, 1'b0, a);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, a);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
